// File: rtl/sram_arb2_if.sv
// -----------------------------------------------------------------------------
// sram_arb2_if
// SRAM-like request/response bundle using the req / addr_ok / data_ok
// handshake of the pipeline stages.
//   master : drives req, wr, size, wstrb, addr, wdata;
//            receives addr_ok, data_ok, rdata
//   slave  : the mirror image of master
// -----------------------------------------------------------------------------
interface sram_arb2_if;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [3:0]  wstrb;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;

  modport master (
    output req, wr, size, wstrb, addr, wdata,
    input  addr_ok, data_ok, rdata
  );

  modport slave (
    input  req, wr, size, wstrb, addr, wdata,
    output addr_ok, data_ok, rdata
  );
endinterface

// File: rtl/sram_arb2.sv
// -----------------------------------------------------------------------------
// sram_arb2
// Two-to-one arbiter sharing one SRAM-like memory port between the IF-stage
// instruction master and the MEM-stage data master. Data is served first; a
// starvation counter forces a waiting inst request through after STARVE_LIMIT
// consecutive data grants. An in-order ID FIFO routes each response back to
// the master that issued the request. Zero added latency on either path.
//   clk     : clock, rising edge
//   reset   : asynchronous, active-high reset
//   inst    : instruction master bus (slave side of the handshake)
//   data    : data master bus (slave side of the handshake)
//   mem     : shared memory bus (master side of the handshake)
//   arb_err : sticky, a response arrived with nothing outstanding
// -----------------------------------------------------------------------------
module sram_arb2 #(
  parameter int OUTSTANDING  = 4,  // power of two, >= 2
  parameter int STARVE_LIMIT = 3
) (
  input  logic        clk,
  input  logic        reset,
  sram_arb2_if.slave  inst,
  sram_arb2_if.slave  data,
  sram_arb2_if.master mem,
  output logic        arb_err
);

  localparam int PW = $clog2(OUTSTANDING);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] FIFO_DEPTH = CW'(OUTSTANDING);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_INST = 2'd1,
    GNT_DATA = 2'd2
  } gnt_e;

  // Encoding stored in the ID FIFO: which master owns the transfer.
  typedef enum logic {
    ID_INST = 1'b0,
    ID_DATA = 1'b1
  } id_e;

  gnt_e          gnt;
  id_e           gnt_id;
  logic          lock_vld;
  id_e           lock_id;
  logic          locked_req;
  logic [SW-1:0] starve_cnt;

  id_e           fifo_mem [OUTSTANDING];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] fifo_cnt;
  logic          fifo_full;
  logic          fifo_empty;
  id_e           head_id;

  logic          accept;
  logic          pop;

  assign fifo_full  = (fifo_cnt == FIFO_DEPTH);
  assign fifo_empty = (fifo_cnt == '0);
  assign head_id    = fifo_mem[rd_ptr];
  assign locked_req = (lock_id == ID_DATA) ? data.req : inst.req;

  // ---------------------------------------------------------------------------
  // Grant selection. Reset forces no grant so every request-path output is 0
  // while reset is held.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can
    // leave it unassigned and infer a latch.
    gnt = GNT_NONE;
    if (reset) begin
      gnt = GNT_NONE;
    end else if (lock_vld && locked_req) begin
      // A stalled request keeps the port until memory takes it or it cancels.
      if (lock_id == ID_DATA) gnt = GNT_DATA;
      else                    gnt = GNT_INST;
    end else if ((starve_cnt == STARVE_MAX) && inst.req) begin
      gnt = GNT_INST;
    end else if (data.req) begin
      gnt = GNT_DATA;
    end else if (inst.req) begin
      gnt = GNT_INST;
    end
  end

  assign gnt_id = id_e'(gnt == GNT_DATA);

  // Request fields follow the granted master; all zero with no grant.
  always_comb begin
    mem.wr    = 1'b0;
    mem.size  = 2'd0;
    mem.wstrb = 4'd0;
    mem.addr  = 32'd0;
    mem.wdata = 32'd0;
    case (gnt)
      GNT_INST: begin
        mem.wr    = inst.wr;
        mem.size  = inst.size;
        mem.wstrb = inst.wstrb;
        mem.addr  = inst.addr;
        mem.wdata = inst.wdata;
      end
      GNT_DATA: begin
        mem.wr    = data.wr;
        mem.size  = data.size;
        mem.wstrb = data.wstrb;
        mem.addr  = data.addr;
        mem.wdata = data.wdata;
      end
      default: ;
    endcase
  end

  // A full FIFO blocks new requests even when a pop lands in the same cycle.
  assign mem.req      = (gnt != GNT_NONE) && !fifo_full;
  assign accept       = mem.req && mem.addr_ok;
  assign inst.addr_ok = accept && (gnt == GNT_INST);
  assign data.addr_ok = accept && (gnt == GNT_DATA);

  // ---------------------------------------------------------------------------
  // Response routing: the FIFO head names the owner of the returning beat.
  // The FIFO count is cleared asynchronously, so pop is 0 during reset.
  // ---------------------------------------------------------------------------
  assign pop          = mem.data_ok && !fifo_empty;
  assign inst.data_ok = pop && (head_id == ID_INST);
  assign data.data_ok = pop && (head_id == ID_DATA);
  assign inst.rdata   = reset ? 32'd0 : mem.rdata;
  assign data.rdata   = reset ? 32'd0 : mem.rdata;

  // ---------------------------------------------------------------------------
  // ID FIFO pointers and occupancy.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + PW'(1);
      if (pop)    rd_ptr <= rd_ptr + PW'(1);
      case ({accept, pop})
        2'b10:   fifo_cnt <= fifo_cnt + CW'(1);
        2'b01:   fifo_cnt <= fifo_cnt - CW'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // NOTE: FIFO storage is not reset; an entry is only read after it has been
  // written, and the reset pointers/count make stale contents unreachable.
  always_ff @(posedge clk) begin
    if (accept) fifo_mem[wr_ptr] <= gnt_id;
  end

  // ---------------------------------------------------------------------------
  // Lock, starvation counter, error flag.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lock_vld <= 1'b0;
      lock_id  <= ID_INST;
    end else if (mem.req && !mem.addr_ok) begin
      // mem_req already excludes a full FIFO, so no lock is taken when full.
      lock_vld <= 1'b1;
      lock_id  <= gnt_id;
    end else if (accept || (lock_vld && !locked_req)) begin
      lock_vld <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (!inst.req) begin
      starve_cnt <= '0;
    end else if (accept && (gnt == GNT_INST)) begin
      starve_cnt <= '0;
    end else if (accept && (gnt == GNT_DATA) && (starve_cnt != STARVE_MAX)) begin
      starve_cnt <= starve_cnt + SW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      arb_err <= 1'b0;
    end else if (mem.data_ok && fifo_empty) begin
      arb_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sram_arb2.sv
// -----------------------------------------------------------------------------
// tb_sram_arb2
// Self-checking bench for sram_arb2: a hand-derived vector table covering the
// documented scenarios, a hand-written asynchronous reset sequence, and a
// randomized run compared cycle by cycle against a queue-based reference model.
// -----------------------------------------------------------------------------
module tb_sram_arb2;

  localparam int OUTSTANDING  = 4;
  localparam int STARVE_LIMIT = 3;
  localparam logic [31:0] IA  = 32'h1C00_0000;
  localparam logic [31:0] DA  = 32'h8000_1000;

  logic clk = 1'b0;
  logic reset;
  logic arb_err;

  always #5 clk = ~clk;

  sram_arb2_if inst_bus ();
  sram_arb2_if data_bus ();
  sram_arb2_if mem_bus ();

  sram_arb2 #(
    .OUTSTANDING  (OUTSTANDING),
    .STARVE_LIMIT (STARVE_LIMIT)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .inst    (inst_bus),
    .data    (data_bus),
    .mem     (mem_bus),
    .arb_err (arb_err)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: a queue of owners (0 = inst, 1 = data) in issue order,
  // plus who is stalled on the port, the run length of data wins, and the
  // sticky error.
  // ---------------------------------------------------------------------------
  typedef struct {
    int          gnt;    // -1 none, 0 inst, 1 data
    logic        mreq;
    logic [31:0] maddr;
    logic [31:0] mwdata;
    logic [6:0]  mctl;   // {wr, size, wstrb}
    logic        iaok, daok, idok, ddok;
    logic [31:0] rd;
    logic        err;
  } exp_t;

  int mq[$];
  bit m_stall_v;
  int m_stall_id;
  int m_data_run;
  bit m_err;

  function automatic bit req_of(input int id);
    return (id == 0) ? inst_bus.req : data_bus.req;
  endfunction

  task automatic model_clear();
    mq.delete();
    m_stall_v  = 1'b0;
    m_stall_id = 0;
    m_data_run = 0;
    m_err      = 1'b0;
  endtask

  task automatic model_eval(output exp_t e);
    int g;
    g = -1;
    if (!reset) begin
      if (m_stall_v && req_of(m_stall_id))                     g = m_stall_id;
      else if (m_data_run == STARVE_LIMIT && inst_bus.req)     g = 0;
      else if (data_bus.req)                                   g = 1;
      else if (inst_bus.req)                                   g = 0;
    end
    e.gnt    = g;
    e.mreq   = (g >= 0) && (mq.size() < OUTSTANDING);
    e.maddr  = 32'd0;
    e.mwdata = 32'd0;
    e.mctl   = 7'd0;
    if (g == 0) begin
      e.maddr  = inst_bus.addr;
      e.mwdata = inst_bus.wdata;
      e.mctl   = {inst_bus.wr, inst_bus.size, inst_bus.wstrb};
    end else if (g == 1) begin
      e.maddr  = data_bus.addr;
      e.mwdata = data_bus.wdata;
      e.mctl   = {data_bus.wr, data_bus.size, data_bus.wstrb};
    end
    e.iaok = e.mreq && mem_bus.addr_ok && (g == 0);
    e.daok = e.mreq && mem_bus.addr_ok && (g == 1);
    e.idok = 1'b0;
    e.ddok = 1'b0;
    if (!reset && mem_bus.data_ok && mq.size() > 0) begin
      e.idok = (mq[0] == 0);
      e.ddok = (mq[0] == 1);
    end
    e.rd  = reset ? 32'd0 : mem_bus.rdata;
    e.err = m_err;
  endtask

  task automatic model_commit(input exp_t e);
    bit taken;
    if (reset) begin
      model_clear();
      return;
    end
    taken = e.mreq && mem_bus.addr_ok;
    if (e.idok || e.ddok)      void'(mq.pop_front());
    else if (mem_bus.data_ok)  m_err = 1'b1;
    if (taken) mq.push_back(e.gnt);
    // Whoever was offered the port and refused stays on it next cycle.
    m_stall_v  = e.mreq && !mem_bus.addr_ok;
    m_stall_id = e.gnt;
    if (!inst_bus.req || (taken && e.gnt == 0))        m_data_run = 0;
    else if (taken && e.gnt == 1)                      m_data_run = (m_data_run < STARVE_LIMIT) ? m_data_run + 1 : STARVE_LIMIT;
  endtask

  exp_t last_e;

  // One clock: inputs were set at the falling edge; check 1 ns later, advance
  // the model, and return at the next falling edge.
  task automatic cycle();
    exp_t e;
    #1;
    model_eval(e);
    check("mem_req",      32'(mem_bus.req),      32'(e.mreq));
    check("mem_addr",     mem_bus.addr,          e.maddr);
    check("mem_wdata",    mem_bus.wdata,         e.mwdata);
    check("mem_ctl",      32'({mem_bus.wr, mem_bus.size, mem_bus.wstrb}), 32'(e.mctl));
    check("inst_addr_ok", 32'(inst_bus.addr_ok), 32'(e.iaok));
    check("data_addr_ok", 32'(data_bus.addr_ok), 32'(e.daok));
    check("inst_data_ok", 32'(inst_bus.data_ok), 32'(e.idok));
    check("data_data_ok", 32'(data_bus.data_ok), 32'(e.ddok));
    check("inst_rdata",   inst_bus.rdata,        e.rd);
    check("data_rdata",   data_bus.rdata,        e.rd);
    check("arb_err",      32'(arb_err),          32'(e.err));
    model_commit(e);
    last_e = e;
    @(negedge clk);
  endtask

  // ---------------------------------------------------------------------------
  // Hand-derived vector table.
  // ---------------------------------------------------------------------------
  typedef struct {
    logic        ireq, dreq, aok, dok;
    logic [31:0] rd;
    logic        mreq;
    logic [31:0] maddr;
    logic        iaok, daok, idok, ddok, err;
  } vec_t;

  vec_t tab[$];

  function automatic vec_t mk(input logic ireq, dreq, aok, dok, input logic [31:0] rd,
                              input logic mreq, input logic [31:0] maddr,
                              input logic iaok, daok, idok, ddok, err);
    vec_t v;
    v.ireq = ireq; v.dreq = dreq; v.aok = aok; v.dok = dok; v.rd = rd;
    v.mreq = mreq; v.maddr = maddr;
    v.iaok = iaok; v.daok = daok; v.idok = idok; v.ddok = ddok; v.err = err;
    return v;
  endfunction

  task automatic fill_table();
    // Data-first: both rise together, data wins, inst next, responses in order.
    tab.push_back(mk(1,1,1,0,32'h0,        1,DA, 0,1,0,0,0));
    tab.push_back(mk(1,0,1,0,32'h0,        1,IA, 1,0,0,0,0));
    tab.push_back(mk(0,0,0,1,32'hAAAA0000, 0,0,  0,0,0,1,0));
    tab.push_back(mk(0,0,0,1,32'h11110000, 0,0,  0,0,1,0,0));
    // Lock: inst stalled three cycles keeps the port while data waits.
    tab.push_back(mk(1,0,0,0,32'h0,        1,IA, 0,0,0,0,0));
    tab.push_back(mk(1,1,0,0,32'h0,        1,IA, 0,0,0,0,0));
    tab.push_back(mk(1,1,0,0,32'h0,        1,IA, 0,0,0,0,0));
    tab.push_back(mk(1,1,1,0,32'h0,        1,IA, 1,0,0,0,0));
    tab.push_back(mk(0,1,1,0,32'h0,        1,DA, 0,1,0,0,0));
    tab.push_back(mk(0,0,0,1,32'h12345678, 0,0,  0,0,1,0,0));
    tab.push_back(mk(0,0,0,1,32'h9ABCDEF0, 0,0,  0,0,0,1,0));
    // Starvation guard: D D D I D D D I, one response per cycle keeps FIFO low.
    tab.push_back(mk(1,1,1,0,32'h0,        1,DA, 0,1,0,0,0));
    tab.push_back(mk(1,1,1,1,32'hC0DE0012, 1,DA, 0,1,0,1,0));
    tab.push_back(mk(1,1,1,1,32'hC0DE0013, 1,DA, 0,1,0,1,0));
    tab.push_back(mk(1,1,1,1,32'hC0DE0014, 1,IA, 1,0,0,1,0));
    tab.push_back(mk(1,1,1,1,32'hC0DE0015, 1,DA, 0,1,1,0,0));
    tab.push_back(mk(1,1,1,1,32'hC0DE0016, 1,DA, 0,1,0,1,0));
    tab.push_back(mk(1,1,1,1,32'hC0DE0017, 1,DA, 0,1,0,1,0));
    tab.push_back(mk(1,1,1,1,32'hC0DE0018, 1,IA, 1,0,0,1,0));
    tab.push_back(mk(0,0,0,1,32'hC0DE0019, 0,0,  0,0,1,0,0));
    // Full FIFO: four accepts, then blocked even in the cycle of a pop.
    tab.push_back(mk(0,1,1,0,32'h0,        1,DA, 0,1,0,0,0));
    tab.push_back(mk(0,1,1,0,32'h0,        1,DA, 0,1,0,0,0));
    tab.push_back(mk(0,1,1,0,32'h0,        1,DA, 0,1,0,0,0));
    tab.push_back(mk(0,1,1,0,32'h0,        1,DA, 0,1,0,0,0));
    tab.push_back(mk(1,1,1,0,32'h0,        0,DA, 0,0,0,0,0));
    tab.push_back(mk(1,1,1,1,32'h0F000025, 0,DA, 0,0,0,1,0));
    tab.push_back(mk(1,1,1,0,32'h0,        1,DA, 0,1,0,0,0));
    tab.push_back(mk(0,0,0,1,32'h0F000027, 0,0,  0,0,0,1,0));
    tab.push_back(mk(0,0,0,1,32'h0F000028, 0,0,  0,0,0,1,0));
    tab.push_back(mk(0,0,0,1,32'h0F000029, 0,0,  0,0,0,1,0));
    tab.push_back(mk(0,0,0,1,32'h0F000030, 0,0,  0,0,0,1,0));
    // Cancel while locked, then a spurious response sets the sticky error.
    tab.push_back(mk(1,0,0,0,32'h0,        1,IA, 0,0,0,0,0));
    tab.push_back(mk(1,1,0,0,32'h0,        1,IA, 0,0,0,0,0));
    tab.push_back(mk(0,1,0,0,32'h0,        1,DA, 0,0,0,0,0));
    tab.push_back(mk(0,1,1,0,32'h0,        1,DA, 0,1,0,0,0));
    tab.push_back(mk(0,0,0,1,32'h55550000, 0,0,  0,0,0,1,0));
    tab.push_back(mk(0,0,0,1,32'h66660000, 0,0,  0,0,0,0,0));
    tab.push_back(mk(0,0,0,0,32'h0,        0,0,  0,0,0,0,1));
    tab.push_back(mk(1,0,1,0,32'h0,        1,IA, 1,0,0,0,1));
    tab.push_back(mk(0,0,0,1,32'h77770000, 0,0,  0,0,1,0,1));
  endtask

  task automatic idle_inputs();
    inst_bus.req = 0; inst_bus.wr = 0; inst_bus.size = 0; inst_bus.wstrb = 0;
    inst_bus.addr = 0; inst_bus.wdata = 0;
    data_bus.req = 0; data_bus.wr = 0; data_bus.size = 0; data_bus.wstrb = 0;
    data_bus.addr = 0; data_bus.wdata = 0;
    mem_bus.addr_ok = 0; mem_bus.data_ok = 0; mem_bus.rdata = 0;
  endtask

  task automatic run_table();
    vec_t v;
    inst_bus.wr = 1'b0; inst_bus.size = 2'd2; inst_bus.wstrb = 4'h0;
    inst_bus.addr = IA; inst_bus.wdata = 32'h0;
    data_bus.wr = 1'b1; data_bus.size = 2'd2; data_bus.wstrb = 4'hF;
    data_bus.addr = DA; data_bus.wdata = 32'hDEADBEEF;
    for (int i = 0; i < tab.size(); i++) begin
      v = tab[i];
      inst_bus.req    = v.ireq;
      data_bus.req    = v.dreq;
      mem_bus.addr_ok = v.aok;
      mem_bus.data_ok = v.dok;
      mem_bus.rdata   = v.rd;
      #1;
      check($sformatf("row%0d_mem_req", i),  32'(mem_bus.req),      32'(v.mreq));
      check($sformatf("row%0d_mem_addr", i), mem_bus.addr,          v.maddr);
      check($sformatf("row%0d_i_aok", i),    32'(inst_bus.addr_ok), 32'(v.iaok));
      check($sformatf("row%0d_d_aok", i),    32'(data_bus.addr_ok), 32'(v.daok));
      check($sformatf("row%0d_i_dok", i),    32'(inst_bus.data_ok), 32'(v.idok));
      check($sformatf("row%0d_d_dok", i),    32'(data_bus.data_ok), 32'(v.ddok));
      check($sformatf("row%0d_arb_err", i),  32'(arb_err),          32'(v.err));
      if (v.idok) check($sformatf("row%0d_i_rdata", i), inst_bus.rdata, v.rd);
      if (v.ddok) check($sformatf("row%0d_d_rdata", i), data_bus.rdata, v.rd);
      #(-1 + 1); // keep sampling time; model cycle below adds its own 1 ns
      cycle_from_offset();
    end
  endtask

  // Same as cycle() but entered 1 ns after the falling edge.
  task automatic cycle_from_offset();
    exp_t e;
    model_eval(e);
    check("mem_req",      32'(mem_bus.req),      32'(e.mreq));
    check("mem_addr",     mem_bus.addr,          e.maddr);
    check("mem_wdata",    mem_bus.wdata,         e.mwdata);
    check("mem_ctl",      32'({mem_bus.wr, mem_bus.size, mem_bus.wstrb}), 32'(e.mctl));
    check("inst_addr_ok", 32'(inst_bus.addr_ok), 32'(e.iaok));
    check("data_addr_ok", 32'(data_bus.addr_ok), 32'(e.daok));
    check("inst_data_ok", 32'(inst_bus.data_ok), 32'(e.idok));
    check("data_data_ok", 32'(data_bus.data_ok), 32'(e.ddok));
    check("arb_err",      32'(arb_err),          32'(e.err));
    model_commit(e);
    last_e = e;
    @(negedge clk);
  endtask

  // Asynchronous reset with two transfers outstanding.
  task automatic run_reset_seq();
    idle_inputs();
    inst_bus.req = 1; inst_bus.addr = IA;
    data_bus.req = 1; data_bus.addr = DA;
    mem_bus.addr_ok = 1;
    cycle();
    cycle();
    check("two_outstanding", 32'(mq.size()), 32'd2);
    mem_bus.addr_ok = 0;
    mem_bus.data_ok = 1;
    mem_bus.rdata   = 32'hFEEDF00D;
    #2;
    reset = 1'b1;
    #1;
    check("rst_mem_req",   32'(mem_bus.req),      32'd0);
    check("rst_mem_addr",  mem_bus.addr,          32'd0);
    check("rst_i_aok",     32'(inst_bus.addr_ok), 32'd0);
    check("rst_d_aok",     32'(data_bus.addr_ok), 32'd0);
    check("rst_i_dok",     32'(inst_bus.data_ok), 32'd0);
    check("rst_d_dok",     32'(data_bus.data_ok), 32'd0);
    check("rst_i_rdata",   inst_bus.rdata,        32'd0);
    check("rst_d_rdata",   data_bus.rdata,        32'd0);
    check("rst_arb_err",   32'(arb_err),          32'd0);
    model_clear();
    @(negedge clk);
    cycle();                       // reset held across a rising edge
    reset = 1'b0;
    inst_bus.req = 0; data_bus.req = 0;
    mem_bus.data_ok = 1; mem_bus.rdata = 32'h0BAD0BAD;
    cycle();                       // late response finds nothing outstanding
    mem_bus.data_ok = 0;
    cycle();
    check("late_resp_err", 32'(arb_err), 32'd1);
  endtask

  // Randomized run: masters hold fields while waiting and may cancel.
  task automatic run_random(input int n);
    idle_inputs();
    last_e.iaok = 0;
    last_e.daok = 0;
    for (int c = 0; c < n; c++) begin
      if (inst_bus.req && !last_e.iaok) begin
        if ($urandom_range(9) == 0) inst_bus.req = 0;
      end else begin
        inst_bus.req = ($urandom_range(1) == 1);
        if (inst_bus.req) begin
          inst_bus.wr    = 1'($urandom);
          inst_bus.size  = 2'($urandom);
          inst_bus.wstrb = 4'($urandom);
          inst_bus.addr  = $urandom;
          inst_bus.wdata = $urandom;
        end
      end
      if (data_bus.req && !last_e.daok) begin
        if ($urandom_range(9) == 0) data_bus.req = 0;
      end else begin
        data_bus.req = ($urandom_range(2) != 0);
        if (data_bus.req) begin
          data_bus.wr    = 1'($urandom);
          data_bus.size  = 2'($urandom);
          data_bus.wstrb = 4'($urandom);
          data_bus.addr  = $urandom;
          data_bus.wdata = $urandom;
        end
      end
      mem_bus.addr_ok = ($urandom_range(4) < 3);
      mem_bus.data_ok = ($urandom_range(4) < 2);
      mem_bus.rdata   = $urandom;
      cycle();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    model_clear();
    idle_inputs();
    reset = 1'b1;
    @(negedge clk);
    cycle();                       // reset state
    reset = 1'b0;
    cycle();                       // idle after reset
    fill_table();
    run_table();
    run_reset_seq();
    run_random(1500);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/sram_arb2.md
Name: sram_arb2

Overview:
- Two-to-one arbiter that shares a single SRAM-like memory port between the IF-stage instruction master and the MEM-stage data master.
- Uses the same req / addr_ok / data_ok handshake as the pipeline stages.
- Serves data requests first, with a starvation guard for instruction fetch.
- Keeps an in-order ID FIFO so that every response is routed back to the master that issued it. It sits between the CPU core and the SRAM-to-AXI bridge.

Parameters:
- OUTSTANDING, 4, maximum accepted-but-unanswered transfers; must be a power of two, at least 2.
- STARVE_LIMIT, 3, number of consecutive data grants after which a waiting inst request is forced through.

Ports:
- clk  in  1  clock; everything samples on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- inst_req / inst_wr / inst_size / inst_wstrb / inst_addr / inst_wdata  in  1/1/2/4/32/32  instruction master request.
- inst_addr_ok  out  1  instruction request accepted.
- inst_data_ok  out  1  instruction response valid.
- inst_rdata  out  32  instruction read data.
- data_req / data_wr / data_size / data_wstrb / data_addr / data_wdata  in  1/1/2/4/32/32  data master request.
- data_addr_ok  out  1  data request accepted.
- data_data_ok  out  1  data response valid.
- data_rdata  out  32  data read data.
- mem_req / mem_wr / mem_size / mem_wstrb / mem_addr / mem_wdata  out  1/1/2/4/32/32  shared request to memory.
- mem_addr_ok  in  1  memory accepted the request.
- mem_data_ok  in  1  memory response valid.
- mem_rdata  in  32  memory read data.
- arb_err  out  1  sticky flag: a response arrived with no outstanding transfer.

Behaviour:
- Grant selection (combinational), evaluated in this order:
  - If lock is set and the locked master still asserts req, that master wins.
  - Else, if starve_cnt equals STARVE_LIMIT and inst_req is high, inst wins.
  - Else, if data_req is high, data wins.
  - Else, if inst_req is high, inst wins.
  - Else, nothing is granted.
- mem_req = granted master's req AND NOT fifo_full. The mem_wr / mem_size / mem_wstrb / mem_addr / mem_wdata fields mux from the granted master; they are zero when nothing is granted.
- X_addr_ok = mem_addr_ok AND mem_req AND (grant == X). The ungranted master's addr_ok is 0.
- Accept event: mem_req AND mem_addr_ok. On accept, push the granted ID into the FIFO (0 = inst, 1 = data).
- Lock register (holds a valid bit and an ID):
  - Set when mem_req is high and mem_addr_ok is low; the lock holds the current grant stable across cycles.
  - Cleared on accept, or when the locked master drops req (a cancel, which is legal).
  - When fifo_full, no lock is taken.
- starve_cnt (width clog2(STARVE_LIMIT+1)):
  - Increments on a data accept while inst_req is high, saturating at STARVE_LIMIT.
  - Clears on an inst accept, or in any cycle where inst_req is low.
- Response routing:
  - On mem_data_ok with the FIFO non-empty, pop the head. Assert inst_data_ok if head = 0, or data_data_ok if head = 1, in the same cycle.
  - mem_rdata is fanned out unregistered to both inst_rdata and data_rdata.
- Response with an empty FIFO: neither data_ok is asserted, no pop occurs, and arb_err is set. arb_err is cleared only by reset.
- FIFO: OUTSTANDING entries, wrap-around read/write pointers, count of width clog2(OUTSTANDING)+1.
  - fifo_full blocks new requests even if a pop happens in the same cycle.
  - A push and a pop in the same cycle (not full) leaves the count unchanged.
- Latency: zero added cycles in both the request and response paths.
- Reset (asynchronous, takes effect immediately): FIFO empty, pointers 0, lock clear, starve_cnt 0, arb_err 0. All outputs are 0 while reset is asserted. Any transfers in flight when reset asserts are discarded.
- Masters must hold request fields stable while req is high and addr_ok is low. The arbiter does not check this.

Test Plan:
- Data-first arbitration: inst_req and data_req rise together and memory returns addr_ok immediately -> data_addr_ok=1 in cycle 0 and inst_addr_ok=1 in cycle 1. Responses arriving in cycles 2 and 3 (rdata 0xAAAA0000, 0x11110000) -> data_data_ok in cycle 2 with data_rdata=0xAAAA0000, then inst_data_ok in cycle 3 with inst_rdata=0x11110000.
- Lock: inst is granted, mem_addr_ok is held low for 3 cycles, and data_req rises in cycle 1 -> mem_addr stays on inst_addr 0x1C000000 until accepted, then data is served.
- Starvation guard: data_req held high, inst_req high, addr_ok always 1, STARVE_LIMIT=3 -> the grant sequence is D, D, D, I, D, D, D, I.
- Full FIFO: 4 accepts with no responses -> mem_req=0 and both addr_ok=0. A 5th accept is possible only in the cycle after the first data_ok.
- Cancel and error: inst drops req while locked -> lock releases and data is granted the next cycle. A spurious mem_data_ok with the FIFO empty -> arb_err=1, no data_ok pulses, and arb_err stays set until reset.
- Reset mid-operation: assert reset with 2 transfers outstanding -> FIFO empties at once, and a later mem_data_ok sets arb_err instead of routing a response.
